mdu_seq: RTL

- Iterative multiply/divide unit for KMA_CPU.
- Sits directly upstream of the accumulator. It drives the accumulator's data input, carry input and clock-enable when a multi-cycle operation finishes.
- Single-cycle ALU ops bypass it. The control unit starts it and stalls on busy.

---
 rtl/mdu_seq_pkg.sv | 33 +++
 rtl/mdu_seq_if.sv | 33 +++
 rtl/mdu_seq_step.sv | 44 ++++
 rtl/mdu_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared definitions for the iterative multiply/divide unit.
//   - Operation encodings (MDU_MULU/MDU_MULS/MDU_DIVQ/MDU_DIVR) as seen on op.
//   - FSM state encodings (MDU_IDLE/MDU_RUN/MDU_DONE).
//   - Fallback for the CPU-wide data width define when definy.v is absent.
// Optional build macro used by the MDU files: MDU_HIGH_EN (adds result_hi).

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package mdu_seq_pkg;

  typedef enum logic [1:0] {
    MDU_MULU = 2'b00,
    MDU_MULS = 2'b01,
    MDU_DIVQ = 2'b10,
    MDU_DIVR = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  localparam int MDU_DEFAULT_WIDTH = `DATA_WIDTH;

  // Divide ops share the top encoding bit; the datapath keys off it.
  function automatic logic mdu_is_div(mdu_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/result bundle between the control unit and mdu_seq.
//   master modport: control unit side (drives start/op/opa/opb).
//   slave  modport: mdu_seq side (drives busy/done/acc_ce/result/cy_o).
// Parameter N is the operand/result width.
// Macro MDU_HIGH_EN: when defined, adds result_hi (N bits) driven by the slave.

interface mdu_seq_if #(parameter int N = mdu_seq_pkg::MDU_DEFAULT_WIDTH);

  logic         start;
  logic [1:0]   op;
  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic         busy;
  logic         done;
  logic         acc_ce;
  logic [N-1:0] result;
  logic         cy_o;

`ifdef MDU_HIGH_EN
  logic [N-1:0] result_hi;

  modport master (output start, op, opa, opb,
                  input  busy, done, acc_ce, result, cy_o, result_hi);
  modport slave  (input  start, op, opa, opb,
                  output busy, done, acc_ce, result, cy_o, result_hi);
`else
  modport master (output start, op, opa, opb,
                  input  busy, done, acc_ce, result, cy_o);
  modport slave  (input  start, op, opa, opb,
                  output busy, done, acc_ce, result, cy_o);
`endif

endinterface

// File: rtl/mdu_seq_step.sv
// mdu_step: one combinational iteration of the MDU datapath.
//   is_div  in   0 = shift-add multiply step, 1 = restoring-divide step
//   acc_i   in   2N-bit working register {high half, low half}
//   b_i     in   multiplicand (multiply) or divisor (divide)
//   acc_o   out  working register after this iteration
// Multiply: low half holds the remaining multiplier bits, high half the
// partial product; the pair shifts right one bit per step.
// Divide: high half is the partial remainder, low half the dividend bits
// being shifted out while quotient bits are shifted in.

module mdu_step #(
  parameter int N = 8
) (
  input  logic           is_div,
  input  logic [2*N-1:0] acc_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] acc_o
);

  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N:0]   sum;
  logic [N:0]   trial;
  logic [N:0]   diff;
  logic         fits;

  always_comb begin
    hi    = acc_i[2*N-1:N];
    lo    = acc_i[N-1:0];
    // Carry out of the add is kept as the new top bit after the right shift.
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_i} : '0);
    // Remainder stays below the divisor, so N+1 bits hold the shifted value.
    trial = {hi, lo[N-1]};
    fits  = (trial >= {1'b0, b_i});
    diff  = trial - {1'b0, b_i};
    if (is_div) begin
      if (fits) acc_o = {diff[N-1:0], lo[N-2:0], 1'b1};
      else      acc_o = {trial[N-1:0], lo[N-2:0], 1'b0};
    end else begin
      acc_o = {sum, lo[N-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit feeding the accumulator.
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave modport of mdu_seq_if:
//         start/op/opa/opb in; busy, done, acc_ce (= done), result, cy_o out
// One iteration per clock; N iterations for every op except divide-by-zero,
// which completes immediately. result/cy_o change only when DONE is entered.
// Macro MDU_HIGH_EN: when defined, also drives bus.result_hi (upper half).

module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int data_width = `DATA_WIDTH,
  parameter int CNT_W      = $clog2(data_width) + 1
) (
  input logic     clk,
  input logic     rst,
  mdu_seq_if.slave bus
);

  localparam int N = data_width;

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     result_q, result_d;
  logic             cy_q, cy_d;
`ifdef MDU_HIGH_EN
  logic [N-1:0]     hi_q, hi_d;
`endif

  mdu_op_e          op_in;
  logic [N-1:0]     opa_mag, opb_mag;
  logic [2*N-1:0]   step_acc, prod_fix;
  logic [N-1:0]     fin_lo, fin_hi;
  logic             fin_cy;

  mdu_step #(.N(N)) u_step (
    .is_div (mdu_is_div(op_q)),
    .acc_i  (acc_q),
    .b_i    (b_q),
    .acc_o  (step_acc)
  );

  // Signed multiply runs on magnitudes; the most negative value maps to
  // 2^(N-1), which still fits N unsigned bits.
  always_comb begin
    op_in   = mdu_op_e'(bus.op);
    opa_mag = bus.opa;
    opb_mag = bus.opb;
    if (op_in == MDU_MULS) begin
      if (bus.opa[N-1]) opa_mag = -bus.opa;
      if (bus.opb[N-1]) opb_mag = -bus.opb;
    end
  end

  // Final values from the last iteration, used on the RUN->DONE edge.
  always_comb begin
    prod_fix = neg_q ? -step_acc : step_acc;
    fin_lo   = '0;
    fin_hi   = '0;
    fin_cy   = 1'b0;
    case (op_q)
      MDU_MULU: begin
        fin_lo = prod_fix[N-1:0];
        fin_hi = prod_fix[2*N-1:N];
        fin_cy = |fin_hi;
      end
      MDU_MULS: begin
        fin_lo = prod_fix[N-1:0];
        fin_hi = prod_fix[2*N-1:N];
        fin_cy = (fin_hi != {N{fin_lo[N-1]}});
      end
      MDU_DIVQ: begin
        fin_lo = step_acc[N-1:0];
        fin_hi = step_acc[2*N-1:N];
      end
      MDU_DIVR: begin
        fin_lo = step_acc[2*N-1:N];
        fin_hi = step_acc[N-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    cy_d     = cy_q;
`ifdef MDU_HIGH_EN
    hi_d     = hi_q;
`endif
    case (state_q)
      MDU_IDLE: begin
        if (bus.start) begin
          op_d  = op_in;
          cnt_d = CNT_W'(N);
          neg_d = (op_in == MDU_MULS) && (bus.opa[N-1] ^ bus.opb[N-1]);
          if (mdu_is_div(op_in)) begin
            b_d   = bus.opb;
            acc_d = {{N{1'b0}}, bus.opa};
            if (bus.opb == '0) begin
              state_d  = MDU_DONE;
              result_d = (op_in == MDU_DIVQ) ? '1 : bus.opa;
              cy_d     = 1'b1;
`ifdef MDU_HIGH_EN
              hi_d     = '0;
`endif
            end else begin
              state_d = MDU_RUN;
            end
          end else begin
            b_d     = opa_mag;
            acc_d   = {{N{1'b0}}, opb_mag};
            state_d = MDU_RUN;
          end
        end
      end
      MDU_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = MDU_DONE;
          result_d = fin_lo;
          cy_d     = fin_cy;
`ifdef MDU_HIGH_EN
          hi_d     = fin_hi;
`endif
        end
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      op_q     <= MDU_MULU;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
`ifdef MDU_HIGH_EN
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      cy_q     <= cy_d;
`ifdef MDU_HIGH_EN
      hi_q     <= hi_d;
`endif
    end
  end

  assign bus.busy   = (state_q != MDU_IDLE);
  assign bus.done   = (state_q == MDU_DONE);
  assign bus.acc_ce = (state_q == MDU_DONE);
  assign bus.result = result_q;
  assign bus.cy_o   = cy_q;
`ifdef MDU_HIGH_EN
  assign bus.result_hi = hi_q;
`endif

endmodule
